dmem_arbiter: RTL

Two-master arbiter and access sequencer for the single-port data memory of the MIPS32 system. It sits between the `mips_main` data port (master 0) and the `Data_memory` instance, and adds a second master port (master 1) for a program loader, DMA or debug engine. It serialises accesses, holds address and data stable for a configurable memory latency, and returns a one-cycle acknowledge with captured read data to the winning master.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single-port MIPS32 data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (master 0).
module dmem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_owner, w_owner_nxt;
  logic        r_is_write, w_is_write_nxt;
  logic        w_any, w_sel, w_done;

  logic              w_mem_write_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic              w_ack0_nxt, w_ack1_nxt;
  logic [DATA_W-1:0] w_rd0_nxt, w_rd1_nxt;

  assign w_any  = m0_req | m1_req;
  assign w_done = (r_cnt == 4'(MEM_LATENCY - 1));

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  // Under contention the master that did not win last time is granted.
  assign w_sel = (m0_req & m1_req) ? ~r_last : m1_req;

  always_ff @(posedge clk) begin
    if (!rst)
      r_last <= 1'b1;
    else if (r_state == S_IDLE && w_any)
      r_last <= w_sel;
  end
`else
  assign w_sel = ~m0_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_any)  w_state_nxt = S_BUSY;
      S_BUSY: if (w_done) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_write_nxt = 1'b0;
    w_mem_addr_nxt  = mem_addr;
    w_mem_wdata_nxt = mem_wdata;
    w_ack0_nxt      = 1'b0;
    w_ack1_nxt      = 1'b0;
    w_rd0_nxt       = m0_rdata;
    w_rd1_nxt       = m1_rdata;
    w_cnt_nxt       = r_cnt;
    w_owner_nxt     = r_owner;
    w_is_write_nxt  = r_is_write;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_owner_nxt     = w_sel;
          w_mem_addr_nxt  = w_sel ? m1_addr  : m0_addr;
          w_mem_wdata_nxt = w_sel ? m1_wdata : m0_wdata;
          w_mem_write_nxt = w_sel ? m1_we    : m0_we;
          w_is_write_nxt  = w_sel ? m1_we    : m0_we;
          w_cnt_nxt       = '0;
        end
      end
      S_BUSY: begin
        if (w_done) begin
          if (!r_is_write) begin
            if (r_owner) w_rd1_nxt = mem_rdata;
            else         w_rd0_nxt = mem_rdata;
          end
          w_ack0_nxt      = ~r_owner;
          w_ack1_nxt      = r_owner;
          w_mem_addr_nxt  = '0;
          w_mem_wdata_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      r_cnt      <= '0;
      r_owner    <= 1'b0;
      r_is_write <= 1'b0;
    end else begin
      mem_write  <= w_mem_write_nxt;
      mem_addr   <= w_mem_addr_nxt;
      mem_wdata  <= w_mem_wdata_nxt;
      m0_ack     <= w_ack0_nxt;
      m1_ack     <= w_ack1_nxt;
      m0_rdata   <= w_rd0_nxt;
      m1_rdata   <= w_rd1_nxt;
      r_cnt      <= w_cnt_nxt;
      r_owner    <= w_owner_nxt;
      r_is_write <= w_is_write_nxt;
    end
  end

endmodule
